// File: rtl/subneg_prog_loader.sv
// Host program loader for the SUBNEG core: synchronizes a strobed byte interface, writes bytes
// sequentially into core memory and holds the core in reset until loading ends.
module subneg_prog_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_en,
    input  logic              stb_raw,
    input  logic [DATA_W-1:0] byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              overflow,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e state_q, state_d;

    logic load_s1_q, load_s2_q;
    logic stb_s1_q, stb_s2_q, stb_s3_q;
    logic stb_edge;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              overflow_q, overflow_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    assign stb_edge = stb_s2_q & ~stb_s3_q;

    // State register; synchronizers run even while ena=0 so no stale edge appears on ena rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            load_s1_q    <= 1'b0;
            load_s2_q    <= 1'b0;
            stb_s1_q     <= 1'b0;
            stb_s2_q     <= 1'b0;
            stb_s3_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rst_n_q <= 1'b0;
            overflow_q   <= 1'b0;
            full_q       <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_s1_q    <= load_en;
            load_s2_q    <= load_s1_q;
            stb_s1_q     <= stb_raw;
            stb_s2_q     <= stb_s1_q;
            stb_s3_q     <= stb_s2_q;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            overflow_q   <= overflow_d;
            full_q       <= full_d;
            checksum_q   <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                StIdle:  if (load_s2_q)  state_d = StLoad;
                StLoad:  if (!load_s2_q) state_d = StRun;
                StRun:   if (load_s2_q)  state_d = StLoad;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rst_n_d = core_rst_n_q;
        overflow_d   = overflow_q;
        full_d       = full_q;
        checksum_d   = checksum_q;
        if (ena) begin
            mem_we_d = 1'b0;
            // Address advances in the cycle after the write pulse.
            if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_W'(1);
            if (state_q == StLoad && stb_edge) begin
                if (!full_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = byte_in;
                    checksum_d  = checksum_q ^ byte_in;
                    if (mem_addr_q == {ADDR_W{1'b1}}) full_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (state_q != StLoad && state_d == StLoad) begin
                mem_addr_d = '0;
                checksum_d = '0;
                overflow_d = 1'b0;
                full_d     = 1'b0;
            end
            // Core released only after one full cycle in RUN; drops as soon as LOAD is entered.
            core_rst_n_d = (state_q == StRun) && (state_d == StRun);
        end
    end

    always_comb begin
        load_done  = (state_q == StRun);
        mem_we     = mem_we_q & ena;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        core_rst_n = core_rst_n_q;
        overflow   = overflow_q;
        checksum   = checksum_q;
    end

endmodule

// File: tb/tb_subneg_prog_loader.sv
// Randomized bench for subneg_prog_loader: bytes are scored against a simple load model
// (expected write list, XOR checksum, full/overflow flags).
module tb_subneg_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       load_en = 1'b0;
    logic       stb_raw = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_rst_n;
    logic       load_done;
    logic       overflow;
    logic [7:0] checksum;

    subneg_prog_loader #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load_en   (load_en),
        .stb_raw   (stb_raw),
        .byte_in   (byte_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst_n(core_rst_n),
        .load_done (load_done),
        .overflow  (overflow),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] obs_q[$];
    logic [12:0] exp_q[$];
    int          m_addr;
    bit          m_full;
    bit          m_ovf;
    logic [7:0]  m_csum;

    always @(negedge clk) if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});

    task automatic model_start();
        m_addr = 0;
        m_full = 0;
        m_ovf  = 0;
        m_csum = 8'h00;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_full) begin
            exp_q.push_back({5'(m_addr), b});
            m_csum ^= b;
            if (m_addr == 31) begin
                m_full = 1;
                m_addr = 0;
            end else begin
                m_addr++;
            end
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        byte_in = b;
        @(negedge clk);
        stb_raw = 1'b1;
        repeat (3) @(negedge clk);
        stb_raw = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_load();
        @(negedge clk);
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        model_start();
    endtask

    task automatic leave_load(input string tag);
        int k;
        @(negedge clk);
        load_en = 1'b0;
        k = 0;
        while (load_done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (load_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_run_entry: load_done=%b required 1", tag, load_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata, core_rst_n, load_done, overflow, checksum} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b addr=%h wd=%h crst=%b done=%b ovf=%b cs=%h required all 0",
                     mem_we, mem_addr, mem_wdata, core_rst_n, load_done, overflow, checksum);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b0 || core_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: done=%b crst=%b required 0/0", load_done, core_rst_n);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4];
        logic [3:0] we_seen;
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        enter_load();
        // First byte checks pulse timing: high only after the 3rd sampling edge.
        @(negedge clk);
        byte_in = bytes[0];
        @(negedge clk);
        stb_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we_seen[i] = mem_we;
        end
        stb_raw = 1'b0;
        repeat (3) @(negedge clk);
        model_byte(bytes[0]);
        n_cmp++;
        if (we_seen !== 4'b0100) begin
            n_bad++;
            $display("FAIL basic_latency: we per cycle=%b required 0100", we_seen);
        end
        for (int i = 1; i < 4; i++) begin
            strobe(bytes[i]);
            model_byte(bytes[i]);
        end
        leave_load("basic");
        n_cmp++;
        if (core_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_core_rst_first: core_rst_n=%b required 0", core_rst_n);
        end
        @(negedge clk);
        n_cmp++;
        if (core_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_core_rst_release: core_rst_n=%b required 1", core_rst_n);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL basic_write%0d: addr/data=%h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (checksum !== m_csum || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_csum: cs=%h ovf=%b required %h/0", checksum, overflow, m_csum);
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] b;
        enter_load();
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            strobe(b);
            model_byte(b);
        end
        leave_load("random");
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL random_write%0d: addr/data=%h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (checksum !== m_csum) begin
            n_bad++;
            $display("FAIL random_csum: cs=%h required %h", checksum, m_csum);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        enter_load();
        for (int i = 0; i < 33; i++) begin
            b = 8'($urandom);
            strobe(b);
            model_byte(b);
        end
        n_cmp++;
        if (obs_q.size() != 32 || exp_q.size() != 32) begin
            n_bad++;
            $display("FAIL ovf_count: writes=%0d required 32", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL ovf_write%0d: addr/data=%h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (overflow !== m_ovf || checksum !== m_csum || mem_addr !== 5'd0) begin
            n_bad++;
            $display("FAIL ovf_flags: ovf=%b cs=%h addr=%h required %b/%h/00",
                     overflow, checksum, mem_addr, m_ovf, m_csum);
        end
        leave_load("ovf");
    endtask

    task automatic test_run_ignore();
        int cnt;
        int k;
        repeat (2) @(negedge clk);
        cnt = obs_q.size();
        strobe(8'($urandom));
        n_cmp++;
        if (obs_q.size() != cnt || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL run_ignore: writes=%0d ovf=%b required %0d/1", obs_q.size(), overflow, cnt);
        end
        @(negedge clk);
        load_en = 1'b1;
        k = 0;
        while (load_done !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (load_done !== 1'b0 || core_rst_n !== 1'b0 || mem_addr !== 5'd0 || checksum !== 8'h00 ||
            overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_entry: done=%b crst=%b addr=%h cs=%h ovf=%b required 0/0/00/00/0",
                     load_done, core_rst_n, mem_addr, checksum, overflow);
        end
        model_start();
    endtask

    task automatic test_simul();
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        strobe(b0);
        model_byte(b0);
        @(negedge clk);
        byte_in = b1;
        @(negedge clk);
        load_en = 1'b0;
        stb_raw = 1'b1;
        model_byte(b1);
        repeat (3) @(negedge clk);
        stb_raw = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_run: load_done=%b required 1", load_done);
        end
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL simul_count: writes=%0d required 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL simul_write%0d: addr/data=%h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (checksum !== m_csum) begin
            n_bad++;
            $display("FAIL simul_csum: cs=%h required %h", checksum, m_csum);
        end
    endtask

    task automatic test_ena();
        logic [7:0] b;
        enter_load();
        b = 8'($urandom);
        strobe(b);
        model_byte(b);
        @(negedge clk);
        ena = 1'b0;
        load_en = 1'b0;
        byte_in = 8'($urandom);
        @(negedge clk);
        stb_raw = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b0) begin
            n_bad++;
            $display("FAIL ena_hold_state: load_done=%b required 0", load_done);
        end
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        stb_raw = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1 || mem_addr !== 5'd1) begin
            n_bad++;
            $display("FAIL ena_drop: writes=%0d addr=%h required 1/01", obs_q.size(), mem_addr);
        end
        b = 8'($urandom);
        strobe(b);
        model_byte(b);
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== exp_q[exp_q.size()-1]) begin
            n_bad++;
            $display("FAIL ena_resume: writes=%0d last=%h required 2/%h", obs_q.size(),
                     obs_q[obs_q.size()-1], exp_q[exp_q.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        enter_load();
        strobe(8'($urandom));
        strobe(8'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata, core_rst_n, load_done, overflow, checksum} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_mid: we=%b addr=%h wd=%h crst=%b done=%b ovf=%b cs=%h required all 0",
                     mem_we, mem_addr, mem_wdata, core_rst_n, load_done, overflow, checksum);
        end
        load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b0 || mem_addr !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_mid_idle: done=%b addr=%h required 0/00", load_done, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_overflow();
        test_run_ignore();
        test_simul();
        test_ena();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
